scr1_pipe_mdu: RTL and testbench
================================

Name: scr1_pipe_mdu

Overview:
- Iterative RV32M multiply/divide unit in the EXU stage, beside the main IALU.
- Consumes the IALU's MUL/DIV command valid and operands; returns the result with a one-cycle result-ready pulse that the IALU muxes onto main_res_o.
- Radix-2 engine, one bit per cycle. Multiply uses shift-add; divide uses restoring division.
- Operands are converted to magnitudes and the sign is fixed up on completion.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  in  1  block clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_vd_i  in  1  MUL/DIV command valid.
- cmd_i  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1_i  in  XLEN  rs1 operand (multiplicand / dividend).
- op2_i  in  XLEN  rs2 operand (multiplier / divisor).
- kill_i  in  1  pipeline flush; aborts any operation in progress.
- res_o  out  XLEN  result; valid while res_rdy_o=1.
- res_rdy_o  out  1  result ready, one-cycle pulse.
- busy_o  out  1  high in BUSY; the IALU stalls the pipe on it.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, regardless of state): state=IDLE, res_o=0, res_rdy_o=0, busy_o=0, counter=0, and all datapath registers cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - cmd_vd_i is sampled only in IDLE.
  - On cmd_vd_i=1 (cycle 0), capture cmd_i, operand magnitudes and result-sign flags; set counter=XLEN-1.
  - Next state is BUSY, except for the fast paths below, which go to DONE.
- Fast paths (no iteration, res_rdy_o in cycle 1):
  - Divide by zero (op2_i=0): DIV/DIVU give all ones; REM/REMU give op1_i.
  - Signed overflow, DIV/REM with op1_i=0x80000000 and op2_i=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- BUSY:
  - busy_o=1; one iteration per cycle; counter decrements.
  - Multiply: 64-bit product register. If the multiplier LSB is 1, add the multiplicand to the high half; then shift right 1.
  - Divide: 32-bit remainder register is shifted left with the next dividend bit. Subtract the divisor if no borrow; the quotient bit is 1 when no borrow occurred.
  - After the iteration at counter=0, go to DONE. BUSY lasts exactly XLEN cycles (cycles 1..32).
- DONE:
  - res_rdy_o=1 for exactly one cycle (cycle 33 for the iterative path); res_o holds the final value.
  - Next state is IDLE. res_o keeps its value until the next command completes; res_rdy_o returns to 0.
- Sign rules:
  - MUL: low 32 bits of the product.
  - MULH: both operands signed. MULHSU: op1 signed, op2 unsigned. MULHU: both unsigned. For all three the result is the high 32 bits.
  - Product is negated if the operand signs differ.
  - DIV: quotient is negated if the operand signs differ. REM: remainder takes the sign of the dividend.
  - DIVU/REMU: no sign correction.
  - Sign correction is applied on the BUSY→DONE transition, so latency is unchanged.
- Pipe handshake:
  - The pipe holds cmd_i, op1_i and op2_i stable from cmd_vd_i high until res_rdy_o.
  - In the cycle after res_rdy_o, the pipe deasserts cmd_vd_i or presents a new command. A command seen in IDLE then starts immediately (back-to-back is allowed).
  - cmd_vd_i in BUSY/DONE is ignored.
- kill_i:
  - In any state, the next state is IDLE.
  - res_rdy_o is forced to 0 in the kill cycle and the following cycle; busy_o goes to 0 the next cycle.
  - kill_i has priority over cmd_vd_i in IDLE (no capture).
  - kill_i in DONE suppresses that cycle's res_rdy_o.
- Reset asserted mid-operation: immediate return to reset values; no result is produced for the aborted op.

Test Plan:
1. MUL 7*6, cmd_vd_i held → busy_o cycles 1..32, res_rdy_o=1 in cycle 33 only, res_o=42.
2. MULH 0x80000000*0x80000000 → 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF. MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
3. DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each with res_rdy_o in cycle 33.
4. Fast paths, each with res_rdy_o in cycle 1 and busy_o never high:
   - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
5. MUL started, kill_i pulsed in cycle 10 → busy_o=0 from cycle 11, no res_rdy_o. A new DIVU 9/3 issued in cycle 12 → res_rdy_o in cycle 45, res_o=3.
6. DIV started, rst asserted mid-cycle 15 → res_o=0, busy_o=0, res_rdy_o=0 immediately (before next edge). After release, MUL 3*3 → 9. Back-to-back MUL then MULHU with no idle gap → both results correct, 34 cycles apart.

Source files
------------

// File: rtl/scr1_pipe_mdu.sv
// scr1_pipe_mdu -- iterative RV32M multiply/divide unit (EXU stage, beside IALU).
// Radix-2, one bit per cycle: shift-add multiply, restoring divide. Operands
// are reduced to magnitudes on capture and the result sign is restored on the
// final iteration, so the sign fix costs no extra cycle.
//
// Ports:
//   clk        block clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_vd_i   MUL/DIV command valid (sampled in IDLE only)
//   cmd_i      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op1_i      rs1 (multiplicand / dividend)
//   op2_i      rs2 (multiplier / divisor)
//   kill_i     pipeline flush, aborts any operation
//   res_o      result, valid while res_rdy_o=1, held until next completion
//   res_rdy_o  one-cycle result-ready pulse
//   busy_o     high while iterating
module scr1_pipe_mdu #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vd_i,
  input  logic [2:0]      cmd_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic [XLEN-1:0] res_o,
  output logic            res_rdy_o,
  output logic            busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [ITER_W-1:0] cnt;
  logic [2:0]        cmd_r;
  logic              neg_r;
  // acc: multiply -> {product high, multiplier/product low};
  //      divide   -> {remainder, dividend shifting out / quotient shifting in}
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   res_r;

  // Capture-side decode
  logic            op1_sgn, op2_sgn, s1, s2, neg_c;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    op1_sgn  = cmd_i[2] ? ~cmd_i[0] : (cmd_i[1:0] != 2'd3);
    op2_sgn  = cmd_i[2] ? ~cmd_i[0] : (cmd_i[1:0] <  2'd2);
    s1       = op1_sgn & op1_i[XLEN-1];
    s2       = op2_sgn & op2_i[XLEN-1];
    mag1     = s1 ? -op1_i : op1_i;
    mag2     = s2 ? -op2_i : op2_i;
    // REM takes the dividend's sign; everything else the sign product
    neg_c    = (cmd_i[2] & cmd_i[1]) ? s1 : (s1 ^ s2);
    div_zero = cmd_i[2] & (op2_i == '0);
    div_ovf  = cmd_i[2] & ~cmd_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) &
               (op2_i == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = cmd_i[1] ? op1_i : '1;
    else          fast_res = cmd_i[1] ? '0 : op1_i;  // overflow: DIV -> op1
  end

  // One iteration of either engine
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh, div_diff;
  logic              borrow;
  logic [XLEN-1:0]   rem_n;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fin_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, opb};
    borrow   = div_diff[XLEN];
    rem_n    = borrow ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
    div_next = {rem_n, acc[XLEN-2:0], ~borrow};
    acc_next = cmd_r[2] ? div_next : mul_next;

    prod_fix = neg_r ? -acc_next : acc_next;
    q_fix    = neg_r ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    r_fix    = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (cmd_r[2])               fin_res = cmd_r[1] ? r_fix : q_fix;
    else if (cmd_r[1:0] == '0)  fin_res = prod_fix[XLEN-1:0];
    else                        fin_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cmd_r <= '0;
      neg_r <= 1'b0;
      acc   <= '0;
      opb   <= '0;
      res_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!kill_i && cmd_vd_i) begin
            cmd_r <= cmd_i;
            neg_r <= neg_c;
            cnt   <= ITER_W'(XLEN-1);
            if (fast) begin
              res_r <= fast_res;
              state <= ST_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, (cmd_i[2] ? mag1 : mag2)};
              opb   <= cmd_i[2] ? mag2 : mag1;
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (kill_i) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              res_r <= fin_res;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign res_o     = res_r;
  assign res_rdy_o = (state == ST_DONE) & ~kill_i;
  assign busy_o    = (state == ST_BUSY);

endmodule

// File: tb/tb_scr1_pipe_mdu.sv
module tb_scr1_pipe_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vd;
  logic [2:0]  cmd;
  logic [31:0] op1, op2;
  logic        kill;
  logic [31:0] res;
  logic        res_rdy, busy;

  int n_cmp = 0;
  int n_err = 0;

  scr1_pipe_mdu #(.XLEN(32), .ITER_W(5)) dut (
    .clk(clk), .rst(rst), .cmd_vd_i(cmd_vd), .cmd_i(cmd), .op1_i(op1),
    .op2_i(op2), .kill_i(kill), .res_o(res), .res_rdy_o(res_rdy), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics straight from 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] c,
                                          input logic [31:0] a, b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (c)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] c, input logic [31:0] a, b);
    if (c >= 3'd4 && b == 0) return 1;
    if ((c == 3'd4 || c == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one command with cmd_vd held until res_rdy; checks latency,
  // result and number of busy cycles. Returns in an IDLE cycle.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, b,
                        input logic [31:0] exp, input int exp_lat,
                        input string name);
    int lat, busy_n;
    logic [31:0] got;
    lat = -1; busy_n = 0; got = 'x;
    @(negedge clk);
    cmd_vd = 1'b1; cmd = c; op1 = a; op2 = b;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (res_rdy) begin lat = i; got = res; cmd_vd = 1'b0; end
      else if (busy) busy_n++;
    end
    cmd_vd = 1'b0;
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d expected %0d (cmd=%0d a=%h b=%h)",
               name, lat, exp_lat, c, a, b);
    end
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h expected %h (cmd=%0d a=%h b=%h)",
               name, got, exp, c, a, b);
    end
    n_cmp++;
    if (busy_n !== ((exp_lat == 1) ? 0 : 32)) begin
      n_err++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n,
               (exp_lat == 1) ? 0 : 32);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_vd = 1'b0; cmd = '0; op1 = '0; op2 = '0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({res, res_rdy, busy} !== 34'h0) begin
      n_err++;
      $display("FAIL reset: res=%h rdy=%b busy=%b expected 0/0/0", res, res_rdy, busy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  tc [14];
    logic [31:0] ta [14], tb [14], te [14];
    int          tl [14];
    tc = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6};
    ta = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
           32'h80000000, 32'h80000000, 32'd5};
    tb = '{32'd6, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    te = '{32'd42, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1,
           32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
           32'h80000000, 32'h0, 32'd5};
    tl = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 1};
    for (int i = 0; i < 14; i++)
      run_op(tc[i], ta[i], tb[i], te[i], tl[i], $sformatf("directed%0d", i));
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 80; i++) begin
      c = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(c, a, b, ref_mdu(c, a, b), ref_lat(c, a, b), "random");
    end
  endtask

  task automatic test_kill();
    int lat, rdy_n, busy_n;
    // kill mid-multiply, then a fresh DIVU issued in cycle 12
    rdy_n = 0; lat = -1; busy_n = 0;
    @(negedge clk);
    cmd_vd = 1'b1; cmd = 3'd0; op1 = 32'd7; op2 = 32'd6;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin kill = 1'b1; cmd_vd = 1'b0; #1; end
      if (i == 11) begin
        kill = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL kill busy: got %b expected 0 in cycle 11", busy);
        end
      end
      if (i <= 12 && res_rdy) rdy_n++;
      if (i == 12) begin cmd_vd = 1'b1; cmd = 3'd5; op1 = 32'd9; op2 = 32'd3; end
      if (i > 12 && res_rdy) begin
        lat = i;
        n_cmp++;
        if (res !== 32'd3) begin
          n_err++;
          $display("FAIL kill restart result: got %h expected 00000003", res);
        end
        cmd_vd = 1'b0;
      end
    end
    n_cmp++;
    if (rdy_n !== 0) begin
      n_err++;
      $display("FAIL kill rdy: got %0d pulses expected 0", rdy_n);
    end
    n_cmp++;
    if (lat !== 45) begin
      n_err++;
      $display("FAIL kill restart latency: got cycle %0d expected 45", lat);
    end
    @(posedge clk);

    // kill in the DONE cycle suppresses res_rdy
    @(negedge clk);
    cmd_vd = 1'b1; cmd = 3'd0; op1 = 32'd5; op2 = 32'd5;
    repeat (33) @(posedge clk);
    #1;
    kill = 1'b1; cmd_vd = 1'b0;
    #1;
    n_cmp++;
    if (res_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL kill done rdy: got %b expected 0", res_rdy);
    end
    n_cmp++;
    if (res !== 32'd25) begin
      n_err++;
      $display("FAIL kill done res: got %h expected 00000019", res);
    end
    @(posedge clk); #1; kill = 1'b0;

    // kill beats cmd_vd in IDLE: nothing captured
    @(negedge clk);
    kill = 1'b1; cmd_vd = 1'b1; cmd = 3'd5; op1 = 32'd9; op2 = 32'd3;
    @(posedge clk); #1;
    kill = 1'b0; cmd_vd = 1'b0;
    busy_n = 0; rdy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (res_rdy) rdy_n++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (busy_n !== 0 || rdy_n !== 0) begin
      n_err++;
      $display("FAIL kill idle: busy=%0d rdy=%0d cycles, expected 0/0", busy_n, rdy_n);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    cmd_vd = 1'b1; cmd = 3'd4; op1 = 32'd100; op2 = 32'd7;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({res, res_rdy, busy} !== 34'h0) begin
      n_err++;
      $display("FAIL rst mid: res=%h rdy=%b busy=%b expected 0/0/0", res, res_rdy, busy);
    end
    @(negedge clk); rst = 1'b0; cmd_vd = 1'b0;
    @(posedge clk);
    run_op(3'd0, 32'd3, 32'd3, 32'd9, 33, "after_rst");
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic [31:0] b2a, b2b;
    t1 = -1; t2 = -1;
    b2a = $urandom; b2b = $urandom;
    @(negedge clk);
    cmd_vd = 1'b1; cmd = 3'd0; op1 = 32'd3; op2 = 32'd3;
    for (int i = 1; i <= 80 && t2 < 0; i++) begin
      @(posedge clk); #1;
      if (res_rdy && t1 < 0) begin
        t1 = i;
        n_cmp++;
        if (res !== 32'd9) begin
          n_err++;
          $display("FAIL b2b first result: got %h expected 00000009", res);
        end
        cmd = 3'd3; op1 = b2a; op2 = b2b;
      end else if (res_rdy) begin
        t2 = i;
        n_cmp++;
        if (res !== ref_mdu(3'd3, b2a, b2b)) begin
          n_err++;
          $display("FAIL b2b second result: got %h expected %h", res,
                   ref_mdu(3'd3, b2a, b2b));
        end
        cmd_vd = 1'b0;
      end
    end
    cmd_vd = 1'b0;
    n_cmp++;
    if (t1 !== 33 || t2 - t1 !== 34) begin
      n_err++;
      $display("FAIL b2b timing: first %0d gap %0d expected 33 and 34", t1, t2 - t1);
    end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
